// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
//
// Shares one single-port block RAM (1-cycle read latency) between two
// requesters. Grants use a bounded-burst round-robin policy: under contention
// a requester keeps the port for at most MAX_BURST consecutive grants before
// the other requester is served. Read data is routed back to the requester
// that issued the read, one cycle after its grant.
//
// Optional feature macro: BRAM_ARB_STATS_EN
//   When defined, adds grant counters per requester and a stall counter.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   mK_req/we/addr/din       requester K access request, write enable,
//                            address and write data (K = 0, 1)
//   mK_gnt                   access accepted this cycle
//   mK_rvalid/rdata          read response for requester K
//   ram_ena/wea/addr/din     RAM port control and write data
//   ram_dout                 RAM read data, valid one cycle after a read
//   m0_gnt_cnt, m1_gnt_cnt,  (BRAM_ARB_STATS_EN only) grant and stall
//   stall_cnt                counters, CW bits, wrap modulo 2^CW
// ---------------------------------------------------------------------------
module bram_arbiter #(
    parameter int N         = 10,
    parameter int B         = 16,
    parameter int MAX_BURST = 4,
    parameter int CW        = 16
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         m0_req,
    input  logic         m0_we,
    input  logic [N-1:0] m0_addr,
    input  logic [B-1:0] m0_din,
    output logic         m0_gnt,
    output logic         m0_rvalid,
    output logic [B-1:0] m0_rdata,

    input  logic         m1_req,
    input  logic         m1_we,
    input  logic [N-1:0] m1_addr,
    input  logic [B-1:0] m1_din,
    output logic         m1_gnt,
    output logic         m1_rvalid,
    output logic [B-1:0] m1_rdata,

    output logic         ram_ena,
    output logic         ram_wea,
    output logic [N-1:0] ram_addr,
    output logic [B-1:0] ram_din,
    input  logic [B-1:0] ram_dout
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [CW-1:0] m0_gnt_cnt,
    output logic [CW-1:0] m1_gnt_cnt,
    output logic [CW-1:0] stall_cnt
`endif
);

    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_t;

    // cnt saturates at MAX_BURST, so it needs just enough bits to hold it.
    localparam int CNTW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_BURST);

    req_id_t         last;
    logic [CNTW-1:0] cnt;
    logic            rd_pend;
    req_id_t         rd_id;

    logic            gnt_any;
    req_id_t         gnt_id;
    logic            keep_last;

    // Under contention the current owner keeps the port only while it is
    // mid-burst; cnt == 0 means the port went idle, so ownership flips.
    assign keep_last = (cnt != '0) && (cnt < CNT_MAX);

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = REQ0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                gnt_any = 1'b1;
                if (keep_last)
                    gnt_id = last;
                else
                    gnt_id = (last == REQ0) ? REQ1 : REQ0;
            end else if (m0_req) begin
                gnt_any = 1'b1;
                gnt_id  = REQ0;
            end else if (m1_req) begin
                gnt_any = 1'b1;
                gnt_id  = REQ1;
            end
        end
    end

    assign m0_gnt = gnt_any && (gnt_id == REQ0);
    assign m1_gnt = gnt_any && (gnt_id == REQ1);

    // RAM port: granted requester's signals, all-zero when idle.
    always_comb begin
        ram_ena  = gnt_any;
        ram_wea  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (m0_gnt) begin
            ram_wea  = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_din;
        end else if (m1_gnt) begin
            ram_wea  = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last    <= REQ0;
            cnt     <= '0;
            rd_pend <= 1'b0;
            rd_id   <= REQ0;
        end else begin
            if (!gnt_any) begin
                cnt <= '0;
            end else if (gnt_id == last) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + CNTW'(1);
            end else begin
                last <= gnt_id;
                cnt  <= CNTW'(1);
            end

            rd_pend <= gnt_any && !ram_wea;
            if (gnt_any && !ram_wea)
                rd_id <= gnt_id;
        end
    end

    // rd_pend is cleared asynchronously, so rvalid drops the moment rst rises.
    assign m0_rvalid = rd_pend && (rd_id == REQ0);
    assign m1_rvalid = rd_pend && (rd_id == REQ1);
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

`ifdef BRAM_ARB_STATS_EN
    logic stall;
    assign stall = (m0_req && !m0_gnt) || (m1_req && !m1_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_gnt_cnt <= '0;
            m1_gnt_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (m0_gnt)
                m0_gnt_cnt <= m0_gnt_cnt + CW'(1);
            if (m1_gnt)
                m1_gnt_cnt <= m1_gnt_cnt + CW'(1);
            if (stall)
                stall_cnt <= stall_cnt + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
//
// Scoreboard bench: a reference model evaluated every cycle predicts grants,
// RAM port values and read responses; expected read data is queued per
// requester and a separate monitor pops it when rvalid is due. A behavioural
// RAM sits on the RAM port. A second instance with MAX_BURST=1 checks strict
// alternation.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

    localparam int N  = 10;
    localparam int B  = 16;
    localparam int MB = 4;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [N-1:0] m0_addr, m1_addr;
    logic [B-1:0] m0_din, m1_din;
    logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [B-1:0] m0_rdata, m1_rdata;
    logic         ram_ena, ram_wea;
    logic [N-1:0] ram_addr;
    logic [B-1:0] ram_din, ram_dout;
`ifdef BRAM_ARB_STATS_EN
    logic [CW-1:0] m0_gnt_cnt, m1_gnt_cnt, stall_cnt;
    logic [CW-1:0] rr_c0, rr_c1, rr_cs;
`endif

    always #5 clk = ~clk;

    bram_arbiter #(.N(N), .B(B), .MAX_BURST(MB), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef BRAM_ARB_STATS_EN
        , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Pure round-robin instance (MAX_BURST = 1); only its grants are checked.
    logic         rr_req0, rr_req1, rr_gnt0, rr_gnt1, rr_rv0, rr_rv1;
    logic [B-1:0] rr_rd0, rr_rd1, rr_rdin;
    logic         rr_ena, rr_wea;
    logic [N-1:0] rr_addr;

    bram_arbiter #(.N(N), .B(B), .MAX_BURST(1), .CW(CW)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_req(rr_req0), .m0_we(1'b0), .m0_addr('0), .m0_din('0),
        .m0_gnt(rr_gnt0), .m0_rvalid(rr_rv0), .m0_rdata(rr_rd0),
        .m1_req(rr_req1), .m1_we(1'b0), .m1_addr('0), .m1_din('0),
        .m1_gnt(rr_gnt1), .m1_rvalid(rr_rv1), .m1_rdata(rr_rd1),
        .ram_ena(rr_ena), .ram_wea(rr_wea), .ram_addr(rr_addr),
        .ram_din(rr_rdin), .ram_dout('0)
`ifdef BRAM_ARB_STATS_EN
        , .m0_gnt_cnt(rr_c0), .m1_gnt_cnt(rr_c1), .stall_cnt(rr_cs)
`endif
    );

    // Behavioural single-port RAM with 1-cycle read latency.
    logic [B-1:0] ram_mem [0:(1<<N)-1];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wea) ram_mem[ram_addr] <= ram_din;
            else         ram_dout <= ram_mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [B-1:0] data;
    } rd_exp_t;

    rd_exp_t      q0[$];
    rd_exp_t      q1[$];
    logic [B-1:0] shadow [0:(1<<N)-1];
    int           cyc = 0;
    int           m_owner = 0;  // requester holding the current streak
    int           m_streak = 0; // consecutive grants in that streak, 0 after idle
    logic         g0_q = 1'b0, g1_q = 1'b0;
`ifdef BRAM_ARB_STATS_EN
    logic [CW-1:0] s_g0 = '0, s_g1 = '0, s_st = '0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        g0_q = m0_gnt;
        g1_q = m1_gnt;
    end

    always @(negedge clk) begin
        int win;
        logic w_we;
        logic [N-1:0] w_addr;
        logic [B-1:0] w_din;
        if (rst) begin
            check("rst_gnt0", m0_gnt, 0);
            check("rst_gnt1", m1_gnt, 0);
            check("rst_ram_ena", ram_ena, 0);
            m_owner  = 0;
            m_streak = 0;
`ifdef BRAM_ARB_STATS_EN
            s_g0 = '0; s_g1 = '0; s_st = '0;
            check("rst_stats", {m0_gnt_cnt, m1_gnt_cnt}, 0);
`endif
        end else begin
            // Contention: owner may continue only mid-burst (1..MB-1 grants so far).
            win = -1;
            if (m0_req && m1_req)
                win = (m_streak > 0 && m_streak < MB) ? m_owner : 1 - m_owner;
            else if (m0_req) win = 0;
            else if (m1_req) win = 1;

            check("gnt0", m0_gnt, win == 0);
            check("gnt1", m1_gnt, win == 1);
            check("ram_ena", ram_ena, win >= 0);

            w_we   = (win == 1) ? m1_we   : m0_we;
            w_addr = (win == 1) ? m1_addr : m0_addr;
            w_din  = (win == 1) ? m1_din  : m0_din;
            if (win >= 0) begin
                check("ram_wea", ram_wea, w_we);
                check("ram_addr", ram_addr, w_addr);
                if (w_we) check("ram_din", ram_din, w_din);
            end else begin
                check("ram_idle", {ram_wea, ram_addr, ram_din}, 0);
            end

`ifdef BRAM_ARB_STATS_EN
            check("m0_gnt_cnt", m0_gnt_cnt, s_g0);
            check("m1_gnt_cnt", m1_gnt_cnt, s_g1);
            check("stall_cnt", stall_cnt, s_st);
            if (win == 0) s_g0 = s_g0 + 1'b1;
            if (win == 1) s_g1 = s_g1 + 1'b1;
            if ((m0_req && win != 0) || (m1_req && win != 1)) s_st = s_st + 1'b1;
`endif

            if (win < 0) begin
                m_streak = 0;
            end else begin
                if (win == m_owner) m_streak = (m_streak + 1 > MB) ? MB : m_streak + 1;
                else begin m_owner = win; m_streak = 1; end
                if (w_we) shadow[w_addr] = w_din;
                else if (win == 0) q0.push_back('{cyc + 1, shadow[w_addr]});
                else q1.push_back('{cyc + 1, shadow[w_addr]});
            end
        end
    end

    // ---------------- read-response monitor ----------------
    always @(negedge clk) begin
        logic e0, e1;
        if (rst) begin
            check("rst_rvalid0", m0_rvalid, 0);
            check("rst_rvalid1", m1_rvalid, 0);
            q0.delete();
            q1.delete();
        end else begin
            e0 = (q0.size() > 0) && (q0[0].due == cyc);
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            check("rvalid0", m0_rvalid, e0);
            check("rvalid1", m1_rvalid, e1);
            if (e0) begin check("rdata0", m0_rdata, q0[0].data); void'(q0.pop_front()); end
            if (e1) begin check("rdata1", m1_rdata, q1[0].data); void'(q1.pop_front()); end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r0, input logic w0, input int a0, input int d0,
                         input logic r1, input logic w1, input int a1, input int d1);
        m0_req = r0; m0_we = w0; m0_addr = N'(a0); m0_din = B'(d0);
        m1_req = r1; m1_we = w1; m1_addr = N'(a1); m1_din = B'(d1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic exp_seq [0:12];

    initial begin
        for (int i = 0; i < (1 << N); i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
        ram_dout = '0;
        rst = 1'b1;
        rr_req0 = 0; rr_req1 = 0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_din = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_din = '0;
        #2;
        check("reset_gnt", {m0_gnt, m1_gnt}, 0);
        check("reset_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("reset_ram_ena", ram_ena, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Write then read-back on m0.
        drive(1, 1, 5, 16'h1234, 0, 0, 0, 0);
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        idle(2);

        // Preload 0..7 with data = addr, then m1 reads them back-to-back.
        for (int a = 0; a < 8; a++) drive(1, 1, a, a, 0, 0, 0, 0);
        for (int a = 0; a < 8; a++) drive(0, 0, 0, 0, 1, 0, a, 0);
        idle(2);

        // m0 alone one cycle, then sustained contention.
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 13; i++) begin
            drive(1, 0, 9, 0, i > 0, 0, 3, 0);
            check("burst_seq", {g0_q, g1_q}, exp_seq[i] ? 2'b01 : 2'b10);
        end
        idle(1);

        // After idle with last = 1, simultaneous requests go to m0.
        drive(0, 0, 0, 0, 1, 0, 2, 0);
        idle(1);
        drive(1, 0, 4, 0, 1, 0, 6, 0);
        check("idle_flip_m0", {g0_q, g1_q}, 2'b10);
        idle(1);

        // MAX_BURST = 1 instance: last = 1 then idle, then strict alternation.
        rr_req1 = 1; @(posedge clk); #1;
        rr_req1 = 0; @(posedge clk); #1;
        rr_req0 = 1; rr_req1 = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_alternate", {rr_gnt0, rr_gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
        end
        rr_req0 = 0; rr_req1 = 0;

        // Reset while an m0 read is in flight.
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        m0_req = 0;
        #1 check("inflight_rvalid", m0_rvalid, 1);
        rst = 1'b1;
        #1;
        check("async_rvalid_drop", m0_rvalid, 0);
        check("async_gnt", {m0_gnt, m1_gnt}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(2);

        // After reset last = 0, cnt = 0: contention hands the port to m1 first.
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, i, 0, 1, 0, i + 1, 0);
            if (i == 0) check("post_rst_first", {g0_q, g1_q}, 2'b01);
        end
`ifdef BRAM_ARB_STATS_EN
        check("stats_sum", 32'(m0_gnt_cnt) + 32'(m1_gnt_cnt), 10);
        check("stats_stall", stall_cnt, 10);
`endif
        idle(2);

        // Randomized traffic; a stalled request holds its fields stable.
        for (int i = 0; i < 600; i++) begin
            if (!(m0_req && !g0_q)) begin
                m0_req  = ($urandom_range(0, 3) != 0);
                m0_we   = 1'($urandom_range(0, 1));
                m0_addr = N'($urandom_range(0, 15));
                m0_din  = B'($urandom);
            end
            if (!(m1_req && !g1_q)) begin
                m1_req  = ($urandom_range(0, 3) != 0);
                m1_we   = 1'($urandom_range(0, 1));
                m1_addr = N'($urandom_range(0, 15));
                m1_din  = B'($urandom);
            end
            @(posedge clk); #1;
        end
        idle(3);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
